// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types and sizing for the PE sequencer: PE packet, PE beat state and sequencer FSM state.
// Optional build macro PE_SEQ_WRB_BCAST_EN (see pe_seq_ctrl.sv).
package pe_seq_ctrl_pkg;

    localparam int DATA_WID = 8;
    localparam int ADDR_B   = 4;
    localparam int CAP_B    = 9;
    localparam int MUL_NUM  = 4;
    localparam int WIN_B    = 8;
    localparam int PIPE_LAT = 4;

    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int BUF_B = cnt_w(MUL_NUM);
    localparam int DRN_B = cnt_w(PIPE_LAT);

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        CNN_FIN = 2'd2
    } PE_STATE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } PE_SEQ_STATE;

    typedef struct packed {
        PE_STATE                          PE_state;
        logic [MUL_NUM-1:0][DATA_WID-1:0] A;
        logic [DATA_WID-1:0]              wrb_data;
        logic [ADDR_B-1:0]                wrb_addr;
        logic [MUL_NUM-1:0]               wrb;
        logic [ADDR_B-1:0]                rdb_addr;
    } PE_IN_PACKET;

    function automatic logic [MUL_NUM-1:0] onehot(input logic [BUF_B-1:0] idx);
        logic [MUL_NUM-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job/stream/packet bundle between the layer controller side (master) and the sequencer (slave).
interface pe_seq_ctrl_if;
    import pe_seq_ctrl_pkg::*;

    logic                             start;
    logic                             clear;
    logic [WIN_B-1:0]                 win_num;
    logic                             w_valid;
    logic [DATA_WID-1:0]              w_data;
    logic                             w_ready;
    logic                             a_valid;
    logic [MUL_NUM-1:0][DATA_WID-1:0] a_data;
    logic                             a_ready;
    logic                             busy;
    logic                             done;
    PE_IN_PACKET                      pe_in_pk;

    modport master (
        output start, clear, win_num, w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, busy, done, pe_in_pk
    );

    modport slave (
        input  start, clear, win_num, w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, busy, done, pe_in_pk
    );

endinterface

// File: rtl/pe_seq_ctrl_mod_cnt.sv
// Up-counter with enable and sync clear that wraps to zero after reaching a (possibly runtime) top value.
module mod_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] top,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = (cnt == top);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE job sequencer: loads kernel weights, streams activation windows, drains the adder pipe.
// Build macro PE_SEQ_WRB_BCAST_EN: one CAP_B-beat load written to all buffers at once.
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    pe_seq_ctrl_if.slave bus
);

    PE_SEQ_STATE       state;
    PE_IN_PACKET       pkt;
    logic              done_q;
    logic [WIN_B-1:0]  win_num_q;

    logic [ADDR_B-1:0] addr_cnt;
    logic              addr_last;
    logic [WIN_B-1:0]  win_cnt;
    logic              win_last;
    logic [DRN_B-1:0]  drn_cnt;
    logic              drn_last;

    logic w_acc, a_acc, fin_beat, load_last;

    assign w_acc    = (state == LOAD) && bus.w_valid;
    assign a_acc    = (state == RUN) && bus.a_valid;
    assign fin_beat = a_acc && addr_last;

    mod_cnt #(.W(ADDR_B)) u_addr_cnt (
        .clk, .reset, .en(w_acc || a_acc), .clr(bus.clear),
        .top(ADDR_B'(CAP_B - 1)), .cnt(addr_cnt), .wrap(addr_last)
    );

`ifdef PE_SEQ_WRB_BCAST_EN
    assign load_last = w_acc && addr_last;
`else
    logic [BUF_B-1:0] buf_cnt;
    logic             buf_last;

    mod_cnt #(.W(BUF_B)) u_buf_cnt (
        .clk, .reset, .en(w_acc && addr_last), .clr(bus.clear),
        .top(BUF_B'(MUL_NUM - 1)), .cnt(buf_cnt), .wrap(buf_last)
    );

    assign load_last = w_acc && addr_last && buf_last;
`endif

    // Window count ends at the latched job size; it is only consulted in RUN, where win_num_q >= 1.
    mod_cnt #(.W(WIN_B)) u_win_cnt (
        .clk, .reset, .en(fin_beat), .clr(bus.clear || (fin_beat && win_last)),
        .top(win_num_q - WIN_B'(1)), .cnt(win_cnt), .wrap(win_last)
    );

    mod_cnt #(.W(DRN_B)) u_drn_cnt (
        .clk, .reset, .en(state == DRAIN), .clr(bus.clear),
        .top(DRN_B'(PIPE_LAT - 1)), .cnt(drn_cnt), .wrap(drn_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pkt       <= '0;
            done_q    <= 1'b0;
            win_num_q <= '0;
        end else begin
            done_q       <= 1'b0;
            pkt.PE_state <= INVALID;
            pkt.wrb      <= '0;
            // clear outranks start and any in-flight beat.
            if (bus.clear) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            win_num_q <= bus.win_num;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (w_acc) begin
                            pkt.wrb_data <= bus.w_data;
                            pkt.wrb_addr <= addr_cnt;
`ifdef PE_SEQ_WRB_BCAST_EN
                            pkt.wrb      <= '1;
`else
                            pkt.wrb      <= onehot(buf_cnt);
`endif
                            if (load_last) state <= (win_num_q == '0) ? DRAIN : RUN;
                        end
                    end
                    RUN: begin
                        if (a_acc) begin
                            pkt.A        <= bus.a_data;
                            pkt.rdb_addr <= addr_cnt;
                            pkt.PE_state <= addr_last ? CNN_FIN : VALID;
                            if (fin_beat && win_last) state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drn_last) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // busy covers the done cycle so it falls together with done.
    assign bus.w_ready  = (state == LOAD);
    assign bus.a_ready  = (state == RUN);
    assign bus.busy     = (state != IDLE) || done_q;
    assign bus.done     = done_q;
    assign bus.pe_in_pk = pkt;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: directed jobs push expected packet beats, a negedge monitor pops and compares.
module tb_pe_seq_ctrl;
    import pe_seq_ctrl_pkg::*;

`ifdef PE_SEQ_WRB_BCAST_EN
    localparam int LOAD_BEATS = CAP_B;
`else
    localparam int LOAD_BEATS = MUL_NUM * CAP_B;
`endif

    typedef struct {
        logic [MUL_NUM-1:0]  wrb;
        logic [ADDR_B-1:0]   addr;
        logic [DATA_WID-1:0] data;
    } wr_exp_t;

    typedef struct {
        PE_STATE                          st;
        logic [MUL_NUM-1:0][DATA_WID-1:0] a;
        logic [ADDR_B-1:0]                addr;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pe_seq_ctrl_if bus ();
    pe_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int          vectors     = 0;
    int          miscompares = 0;
    int          done_seen   = 0;
    int          fin_seen    = 0;
    wr_exp_t     wq[$];
    rd_exp_t     rq[$];
    PE_IN_PACKET final_exp   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every write/read beat on the packet must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.done) done_seen++;
            if (bus.pe_in_pk.wrb != '0) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 64'(bus.pe_in_pk.wrb), 64'd0);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    check("wrb", 64'(bus.pe_in_pk.wrb), 64'(e.wrb));
                    check("wrb_addr", 64'(bus.pe_in_pk.wrb_addr), 64'(e.addr));
                    check("wrb_data", 64'(bus.pe_in_pk.wrb_data), 64'(e.data));
                end
            end
            if (bus.pe_in_pk.PE_state != INVALID) begin
                if (bus.pe_in_pk.PE_state == CNN_FIN) fin_seen++;
                if (rq.size() == 0) begin
                    check("rd_unexpected", 64'(bus.pe_in_pk.PE_state), 64'(INVALID));
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    check("PE_state", 64'(bus.pe_in_pk.PE_state), 64'(e.st));
                    check("A", 64'(bus.pe_in_pk.A), 64'(e.a));
                    check("rdb_addr", 64'(bus.pe_in_pk.rdb_addr), 64'(e.addr));
                end
            end
        end
    end

    task automatic start_job(input int n);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_num = WIN_B'(n);
    endtask

    task automatic load(input bit stall);
        int k;
        k = 0;
        for (int cyc = 0; k < LOAD_BEATS; cyc++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.w_valid = !(stall && (cyc % 2 == 1));
            bus.w_data  = DATA_WID'(k + 1);
            check("w_ready", 64'(bus.w_ready), 64'd1);
            if (cyc == 0) check("busy_start", 64'(bus.busy), 64'd1);
            if (bus.w_valid) begin
                wr_exp_t e;
`ifdef PE_SEQ_WRB_BCAST_EN
                e.wrb = '1;
`else
                e.wrb = MUL_NUM'(1) << (k / CAP_B);
`endif
                e.addr = ADDR_B'(k % CAP_B);
                e.data = DATA_WID'(k + 1);
                wq.push_back(e);
                final_exp.wrb_data = e.data;
                final_exp.wrb_addr = e.addr;
                k++;
            end
        end
    endtask

    task automatic run(input int nwin, input bit stall, input int stop_at);
        int k, total;
        k     = 0;
        total = (stop_at >= 0) ? stop_at : nwin * CAP_B;
        for (int cyc = 0; k < total; cyc++) begin
            @(negedge clk);
            bus.w_valid = 1'b0;
            bus.a_valid = !(stall && (cyc % 2 == 1));
            for (int i = 0; i < MUL_NUM; i++) bus.a_data[i] = DATA_WID'(16 * i + k % CAP_B);
            check("a_ready", 64'(bus.a_ready), 64'd1);
            if (cyc == 0) check("w_ready_off", 64'(bus.w_ready), 64'd0);
            if (bus.a_valid) begin
                rd_exp_t e;
                e.st   = (k % CAP_B == CAP_B - 1) ? CNN_FIN : VALID;
                e.a    = bus.a_data;
                e.addr = ADDR_B'(k % CAP_B);
                rq.push_back(e);
                final_exp.A        = e.a;
                final_exp.rdb_addr = e.addr;
                k++;
            end
        end
    endtask

    // Last beat was accepted at the edge before the first negedge here.
    task automatic expect_done(input string tag, input int fins);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < PIPE_LAT; i++) begin
            @(negedge clk);
            bus.w_valid = 1'b0;
            bus.a_valid = 1'b0;
            check({tag, "_done_early"}, 64'(bus.done), 64'd0);
            check({tag, "_busy_drain"}, 64'(bus.busy), 64'd1);
        end
        @(negedge clk);
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        check({tag, "_final_pkt"}, 64'(bus.pe_in_pk), 64'(final_exp));
        @(negedge clk);
        check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
        check({tag, "_done_count"}, 64'(done_seen - d0), 64'd1);
        check({tag, "_fin_count"}, 64'(fin_seen), 64'(fins));
        check({tag, "_wq_empty"}, 64'(wq.size()), 64'd0);
        check({tag, "_rq_empty"}, 64'(rq.size()), 64'd0);
        fin_seen = 0;
    endtask

    initial begin
        int d0;
        bus.start   = 1'b0;
        bus.clear   = 1'b0;
        bus.win_num = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;

        #12;
        check("rst_pkt", 64'(bus.pe_in_pk), 64'd0);
        check("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check("rst_a_ready", 64'(bus.a_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic job, one window.
        start_job(1);
        load(1'b0);
        run(1, 1'b0, -1);
        expect_done("basic", 1);

        // Every-other-cycle stalls on both streams.
        start_job(1);
        load(1'b1);
        run(1, 1'b1, -1);
        expect_done("stall", 1);

        // Three windows.
        start_job(3);
        load(1'b0);
        run(3, 1'b0, -1);
        expect_done("multi", 3);

        // Clear mid-RUN at rdb_addr 4, restart two cycles later.
        d0 = done_seen;
        start_job(1);
        load(1'b0);
        run(1, 1'b0, 5);
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.clear   = 1'b1;
        check("clr_rdb_addr", 64'(bus.pe_in_pk.rdb_addr), 64'd4);
        @(negedge clk);
        bus.clear = 1'b0;
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_a_ready", 64'(bus.a_ready), 64'd0);
        check("clr_state", 64'(bus.pe_in_pk.PE_state), 64'(INVALID));
        start_job(1);
        check("clr_no_done", 64'(done_seen - d0), 64'd0);
        fin_seen = 0;
        load(1'b0);
        run(1, 1'b0, -1);
        expect_done("restart", 1);

        // Asynchronous reset mid-RUN, then a zero-window job.
        start_job(2);
        load(1'b0);
        run(2, 1'b0, 3);
        @(negedge clk);
        bus.a_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_pkt", 64'(bus.pe_in_pk), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_a_ready", 64'(bus.a_ready), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_rq_empty", 64'(rq.size()), 64'd0);
        @(negedge clk);
        reset     = 1'b1;
        final_exp = '0;
        fin_seen  = 0;
        start_job(0);
        load(1'b0);
        expect_done("zero", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
